// File: rtl/unit_arbiter_if.sv
// unit_arbiter_if: thread request bundle plus the shared downstream
// execution-unit port, as seen by the arbiter (slave) and its users (master).
interface unit_arbiter_if #(
   parameter int N_THREADS = 4,
   parameter int N_ARGS    = 3,
   parameter int W         = 32,
   parameter int SEL_W     = 2
);
   localparam int GW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

   logic [N_THREADS-1:0]                    req_valid;
   logic [N_THREADS-1:0][SEL_W-1:0]         req_sel;
   logic [N_THREADS-1:0][N_ARGS-1:0][W-1:0] req_in;
   logic [N_THREADS-1:0]                    req_lock;
   logic [N_THREADS-1:0]                    req_ready;
   logic [W-1:0]                            resp_data;
   logic [SEL_W-1:0]                        unit_sel;
   logic [N_ARGS-1:0][W-1:0]                unit_in;
   logic [W-1:0]                            unit_out;
   logic                                    unit_ready;
   logic [GW-1:0]                           grant_id;
   logic                                    busy;

   modport master (
      output req_valid,
      output req_sel,
      output req_in,
      output req_lock,
      output unit_out,
      output unit_ready,
      input  req_ready,
      input  resp_data,
      input  unit_sel,
      input  unit_in,
      input  grant_id,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_sel,
      input  req_in,
      input  req_lock,
      input  unit_out,
      input  unit_ready,
      output req_ready,
      output resp_data,
      output unit_sel,
      output unit_in,
      output grant_id,
      output busy
   );
endinterface

// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin sharing of one execution-unit port among
// N_THREADS sequencers, with a bounded lock across consecutive transactions.
module unit_arbiter #(
   parameter int N_THREADS = 4,
   parameter int N_ARGS    = 3,
   parameter int W         = 32,
   parameter int SEL_W     = 2,
   parameter int LOCK_MAX  = 4
) (
   input logic           clk,
   input logic           rst,
   unit_arbiter_if.slave bus
);
   localparam int GW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
   localparam int CW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] g_q, g_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;

   logic [GW-1:0] winner;
   logic [GW-1:0] cand;
   logic [GW-1:0] g_nxt;
   logic          found;
   logic          done;
   logic          in_busy;
   int            idx;

   function automatic logic [GW-1:0] next_id(input logic [GW-1:0] t);
      if (int'(t) == N_THREADS - 1) begin
         return '0;
      end
      return t + GW'(1);
   endfunction

   // First requester at or after rr_ptr, wrapping modulo N_THREADS.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N_THREADS; i++) begin
         idx  = (int'(rr_ptr_q) + i) % N_THREADS;
         cand = GW'(idx);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign g_nxt = next_id(g_q);

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      done       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               g_d     = winner;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A withdrawn request aborts even if the unit answers now.
            if (!bus.req_valid[g_q]) begin
               state_d    = IDLE;
               rr_ptr_d   = g_nxt;
               lock_cnt_d = '0;
            end else if (bus.unit_ready) begin
               done     = 1'b1;
               rr_ptr_d = g_nxt;
               if (bus.req_lock[g_q] &&
                   (lock_cnt_q < CW'(LOCK_MAX - 1))) begin
                  state_d    = LOCKED;
                  lock_cnt_d = lock_cnt_q + CW'(1);
               end else begin
                  state_d    = IDLE;
                  lock_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            if (bus.req_valid[g_q]) begin
               state_d = BUSY;
            end else if (!bus.req_lock[g_q]) begin
               state_d    = IDLE;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         g_q        <= '0;
         rr_ptr_q   <= '0;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Downstream port and completion are pass-through so a combinational
   // unit finishes in the first BUSY cycle.
   assign in_busy       = (state_q == BUSY);
   assign bus.unit_sel  = in_busy ? bus.req_sel[g_q] : '0;
   assign bus.unit_in   = in_busy ? bus.req_in[g_q] : '0;
   assign bus.resp_data = done ? bus.unit_out : '0;
   assign bus.req_ready = done ? (N_THREADS'(1) << g_q) : '0;
   assign bus.grant_id  = g_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/unit_arbiter.md
# unit_arbiter

Shares one downstream execution-unit port (ALU/MEM, selected by `unit_sel`) among `N_THREADS` thread sequencers so that several hardware threads can run on one set of units. Each thread presents a request of unit select plus `N_ARGS` operand words. The block grants requests round-robin, holds the grant until the unit signals completion, and returns the result with a one-cycle per-thread ready pulse. An optional bounded lock keeps the grant across consecutive transactions, for example a load followed by its dependent store.

## Interface

Parameters:
- `N_THREADS`, 4: number of requesting threads, ≥2.
- `N_ARGS`, 3: operand words per request.
- `W`, 32: word width.
- `SEL_W`, 2: unit select width; value 0 means NONE.
- `LOCK_MAX`, 4: maximum consecutive locked completions before a forced release, ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, `N_THREADS`: thread t requests a unit.
- `req_sel`, in, `N_THREADS×SEL_W`: unit select per thread.
- `req_in`, in, `N_THREADS×N_ARGS×W`: operands per thread.
- `req_lock`, in, `N_THREADS`: keep the grant after this transaction completes.
- `req_ready`, out, `N_THREADS`: one-hot completion pulse.
- `resp_data`, out, `W`: unit result. Valid only while a `req_ready` bit is high.
- `unit_sel`, out, `SEL_W`: downstream select.
- `unit_in`, out, `N_ARGS×W`: downstream operands.
- `unit_out`, in, `W`: downstream result.
- `unit_ready`, in, 1: downstream completion, sampled only in BUSY.
- `grant_id`, out, `clog2(N_THREADS)`: current grant holder. Meaningful only in BUSY/LOCKED.
- `busy`, out, 1: state is not IDLE.

## Operation

State registers:
- `state` ∈ {IDLE, BUSY, LOCKED}.
- `g` (grant).
- `rr_ptr` (round-robin pointer).
- `lock_cnt` (0..`LOCK_MAX`).

IDLE:
- `unit_sel` = 0 and `unit_in` = 0.
- If any `req_valid` is set, the winner is the first set bit scanning `rr_ptr`, `rr_ptr`+1, … modulo `N_THREADS`.
- The winner is registered into `g` and the state moves to BUSY.

BUSY:
- `unit_sel` = `req_sel[g]` and `unit_in` = `req_in[g]`, both combinational pass-through.
- The thread must hold its inputs stable until `req_ready[g]`.
- When `unit_ready` is high:
  - `req_ready[g]` = 1 and `resp_data` = `unit_out` in the same cycle.
  - `rr_ptr` ← (`g`+1) mod `N_THREADS`.
  - If `req_lock[g]` is high and `lock_cnt` < `LOCK_MAX`−1: go to LOCKED and increment `lock_cnt`.
  - Otherwise: go to IDLE and clear `lock_cnt`.
- If `req_valid[g]` drops before `unit_ready`, the transaction is aborted:
  - Go to IDLE with no ready pulse.
  - `rr_ptr` ← `g`+1 and `lock_cnt` ← 0.

LOCKED:
- `unit_sel` = 0 and `unit_in` = 0. Other threads are not arbitrated.
- If `req_valid[g]` is high: go to BUSY with the same `g`. No arbitration takes place.
- Otherwise, if `req_lock[g]` is low: go to IDLE and clear `lock_cnt`.
- Otherwise: stay in LOCKED.

Outputs:
- `req_ready` is all-zero except during the BUSY completion cycle.
- `resp_data` = 0 whenever no `req_ready` bit is high.
- `grant_id` = `g`.

## Timing

Reset values:
- `state` = IDLE, `g` = 0, `rr_ptr` = 0, `lock_cnt` = 0.
- `unit_sel` = 0, `unit_in` = 0, `req_ready` = 0, `resp_data` = 0, `busy` = 0.
- Reset asserted mid-transaction returns to IDLE immediately, with no ready pulse.

Latency and throughput:
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle n is presented downstream at cycle n+1.
- A combinational unit (`unit_ready` already high in the first BUSY cycle) completes at n+1.
- A multi-cycle unit completes in the first BUSY cycle in which `unit_ready` is high.
- Unlocked back-to-back transactions cost one IDLE bubble each (BUSY, IDLE, BUSY). Peak rate is 1 transaction per 2 cycles.
- Locked continuation: completion, then LOCKED, then BUSY, also one bubble, with a guaranteed grant.

Fairness and lock bound:
- After thread t completes, t has the lowest priority.
- Every continuously requesting thread is granted within (`N_THREADS`−1)·(`LOCK_MAX`) transactions.
- The `LOCK_MAX`-th consecutive locked completion forces IDLE even if `req_lock` is high.

Boundary cases:
- Pointer wrap: `g` = `N_THREADS`−1 gives `rr_ptr` = 0.
- A request with `req_sel` = 0 (NONE) is still granted. It waits for `unit_ready` like any other request.
- `unit_ready` high in IDLE or LOCKED is ignored.

## Test plan

1. Reset, then `req_valid`=0001 with `req_sel[0]`=1 and `unit_ready` held at 1.
   - Cycle 1: `unit_sel`=1.
   - Cycle 1: `req_ready`=0001.
   - Cycle 1: `resp_data`=`unit_out`=0x0000_1234.
   - Cycle 2: IDLE.
2. `req_valid`=1111 held, `unit_ready`=1, 8 transactions.
   - Grant order: 0,1,2,3,0,1,2,3.
   - `req_ready` pulses every 2nd cycle.
3. `unit_ready` delayed 3 cycles for thread 2.
   - `unit_in` is stable for 3 BUSY cycles.
   - A single `req_ready`=0100 pulse on the 3rd cycle.
   - No other thread is granted meanwhile.
4. Thread 1 with `req_lock`=1 held, `LOCK_MAX`=4, thread 3 also requesting.
   - Thread 1 completes 4 consecutive transactions.
   - Forced release follows.
   - Next grant goes to 3.
5. Thread 0 drops `req_valid` in BUSY before `unit_ready`.
   - No pulse; the block returns to IDLE.
   - Next grant goes to thread 1 if it is requesting.
6. `rst` asserted in BUSY while `unit_ready`=1: all outputs return to their reset values asynchronously, and no `req_ready` pulse occurs.
